ay_bus_sequencer: RTL and testbench

//  Sole owner of the YM2149 bus pins (DA, BDIR, BC1). Shares the PSG between the CPU

---
 rtl/ay_bus_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_ay_bus_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ay_bus_sequencer.sv
// ay_bus_sequencer: sole driver of the YM2149 bus pins (DA, BDIR, BC1).
// Merges CPU port-14/15 writes with a register-player requester and emits
// every write as an atomic latch-address / write-data / gap sequence so the
// PSG address latch can never be clobbered by the other requester.
module ay_bus_sequencer #(
  parameter int unsigned PHASE_CE = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_data,
  input  logic       cpu_wren,
  input  logic       pl_req,
  input  logic [3:0] pl_reg,
  input  logic [7:0] pl_data,
  output logic       pl_ack,
  output logic [7:0] ay_data,
  output logic       ay_bdir,
  output logic       ay_bc1,
  output logic       busy,
  input  logic       ovf_clr,
  output logic       cpu_ovf
);

  localparam logic [3:0] LAST_CE = 4'(PHASE_CE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [3:0] cpu_addr, cpu_addr_next;
  logic       pend_valid, pend_valid_next;
  logic [3:0] pend_reg, pend_reg_next;
  logic [7:0] pend_data, pend_data_next;
  logic [3:0] txn_reg, txn_reg_next;
  logic [7:0] txn_data, txn_data_next;
  logic       pl_ack_next;
  logic       cpu_ovf_next;
  logic       ovf_set;
  logic       cpu_data_wr;
  logic [7:0] ay_data_next;
  logic       ay_bdir_next;
  logic       ay_bc1_next;
  logic       busy_next;

  assign cpu_data_wr = cpu_wren & ~cpu_a0;

  // Next-state, arbitration, CPU pending slot and registered-output values
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    cpu_addr_next   = cpu_addr;
    pend_valid_next = pend_valid;
    pend_reg_next   = pend_reg;
    pend_data_next  = pend_data;
    txn_reg_next    = txn_reg;
    txn_data_next   = txn_data;
    pl_ack_next     = 1'b0;
    ovf_set         = 1'b0;
    ay_data_next    = 8'h00;
    ay_bdir_next    = 1'b0;
    ay_bc1_next     = 1'b0;

    case (state)
      IDLE: begin
        // A CPU data strobe arriving this edge holds the player off so the
        // CPU write that was issued at the same time is still served first.
        if (pend_valid) begin
          state_next      = ADDR;
          cnt_next        = 4'd0;
          txn_reg_next    = pend_reg;
          txn_data_next   = pend_data;
          pend_valid_next = 1'b0;
        end else if (pl_req && !cpu_data_wr) begin
          state_next    = ADDR;
          cnt_next      = 4'd0;
          txn_reg_next  = pl_reg;
          txn_data_next = pl_data;
          pl_ack_next   = 1'b1;
        end
      end
      ADDR, DATA, GAP: begin
        if (ce) begin
          if (cnt == LAST_CE) begin
            cnt_next = 4'd0;
            case (state)
              ADDR:    state_next = DATA;
              DATA:    state_next = GAP;
              default: state_next = IDLE;
            endcase
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase

    // The pending slot is tested after the grant so a slot freed on this
    // edge can take the new write without flagging an overflow.
    if (cpu_wren) begin
      if (cpu_a0) begin
        cpu_addr_next = cpu_data[3:0];
      end else if (!pend_valid_next) begin
        pend_valid_next = 1'b1;
        pend_reg_next   = cpu_addr;
        pend_data_next  = cpu_data;
      end else begin
        ovf_set = 1'b1;
      end
    end

    if (ovf_set) begin
      cpu_ovf_next = 1'b1;
    end else if (ovf_clr) begin
      cpu_ovf_next = 1'b0;
    end else begin
      cpu_ovf_next = cpu_ovf;
    end

    case (state_next)
      ADDR: begin
        ay_bdir_next = 1'b1;
        ay_bc1_next  = 1'b1;
        ay_data_next = {4'h0, txn_reg_next};
      end
      DATA: begin
        ay_bdir_next = 1'b1;
        ay_bc1_next  = 1'b0;
        ay_data_next = txn_data_next;
      end
      default: begin
        ay_bdir_next = 1'b0;
        ay_bc1_next  = 1'b0;
        ay_data_next = 8'h00;
      end
    endcase

    busy_next = (state_next != IDLE) | pend_valid_next;
  end

  // State, datapath and output registers; reset drops the bus immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cpu_addr   <= 4'd0;
      pend_valid <= 1'b0;
      pend_reg   <= 4'd0;
      pend_data  <= 8'h00;
      txn_reg    <= 4'd0;
      txn_data   <= 8'h00;
      pl_ack     <= 1'b0;
      cpu_ovf    <= 1'b0;
      ay_data    <= 8'h00;
      ay_bdir    <= 1'b0;
      ay_bc1     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      cpu_addr   <= cpu_addr_next;
      pend_valid <= pend_valid_next;
      pend_reg   <= pend_reg_next;
      pend_data  <= pend_data_next;
      txn_reg    <= txn_reg_next;
      txn_data   <= txn_data_next;
      pl_ack     <= pl_ack_next;
      cpu_ovf    <= cpu_ovf_next;
      ay_data    <= ay_data_next;
      ay_bdir    <= ay_bdir_next;
      ay_bc1     <= ay_bc1_next;
      busy       <= busy_next;
    end
  end

endmodule

// File: tb/tb_ay_bus_sequencer.sv
// tb_ay_bus_sequencer: directed, self-checking bench for ay_bus_sequencer.
// Bus values are compared as {bdir, bc1, data}: ADDR = 3xx, DATA = 2xx, idle = 000.
module tb_ay_bus_sequencer;

  logic       clk;
  logic       reset_n;
  logic       ce;
  logic       ce2;
  logic       cpu_a0;
  logic [7:0] cpu_data;
  logic       cpu_wren;
  logic       pl_req;
  logic [3:0] pl_reg;
  logic [7:0] pl_data;
  logic       ovf_clr;

  logic       pl_ack, pl_ack2;
  logic [7:0] ay_data, ay_data2;
  logic       ay_bdir, ay_bdir2;
  logic       ay_bc1, ay_bc12;
  logic       busy, busy2;
  logic       cpu_ovf, cpu_ovf2;

  logic [9:0] bus1, bus2;
  assign bus1 = {ay_bdir, ay_bc1, ay_data};
  assign bus2 = {ay_bdir2, ay_bc12, ay_data2};

  int total;
  int bad;

  ay_bus_sequencer #(.PHASE_CE(1)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .cpu_a0(cpu_a0),
    .cpu_data(cpu_data), .cpu_wren(cpu_wren), .pl_req(pl_req),
    .pl_reg(pl_reg), .pl_data(pl_data), .pl_ack(pl_ack),
    .ay_data(ay_data), .ay_bdir(ay_bdir), .ay_bc1(ay_bc1), .busy(busy),
    .ovf_clr(ovf_clr), .cpu_ovf(cpu_ovf)
  );

  ay_bus_sequencer #(.PHASE_CE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .ce(ce2), .cpu_a0(cpu_a0),
    .cpu_data(cpu_data), .cpu_wren(cpu_wren), .pl_req(pl_req),
    .pl_reg(pl_reg), .pl_data(pl_data), .pl_ack(pl_ack2),
    .ay_data(ay_data2), .ay_bdir(ay_bdir2), .ay_bc1(ay_bc12), .busy(busy2),
    .ovf_clr(ovf_clr), .cpu_ovf(cpu_ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick;
    total++;
    if (bus1 !== 10'h000 || busy !== 1'b0 || pl_ack !== 1'b0 || cpu_ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_dut1 bus=%h busy=%b ack=%b ovf=%b, expected 000/0/0/0", bus1, busy, pl_ack, cpu_ovf);
    end
    total++;
    if (bus2 !== 10'h000 || busy2 !== 1'b0 || pl_ack2 !== 1'b0 || cpu_ovf2 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_dut2 bus=%h busy=%b ack=%b ovf=%b, expected 000/0/0/0", bus2, busy2, pl_ack2, cpu_ovf2);
    end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_cpu_write;
    cpu_wren = 1'b1; cpu_a0 = 1'b1; cpu_data = 8'h07;
    tick;
    cpu_a0 = 1'b0; cpu_data = 8'h38;
    tick;
    cpu_wren = 1'b0;
    total++;
    if (bus1 !== 10'h000 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL cpu_pending bus=%h busy=%b, expected 000/1", bus1, busy);
    end
    tick;
    total++;
    if (bus1 !== 10'h307) begin
      bad++;
      $display("[TB] FAIL cpu_addr_phase bus=%h, expected 307", bus1);
    end
    tick;
    total++;
    if (bus1 !== 10'h238) begin
      bad++;
      $display("[TB] FAIL cpu_data_phase bus=%h, expected 238", bus1);
    end
    tick;
    total++;
    if (bus1 !== 10'h000 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL cpu_gap bus=%h busy=%b, expected 000/1", bus1, busy);
    end
    tick;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL cpu_idle busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_player;
    pl_req = 1'b1; pl_reg = 4'h3; pl_data = 8'h55;
    tick;
    total++;
    if (pl_ack !== 1'b1 || bus1 !== 10'h303) begin
      bad++;
      $display("[TB] FAIL pl_grant ack=%b bus=%h, expected 1/303", pl_ack, bus1);
    end
    pl_req = 1'b0;
    tick;
    total++;
    if (pl_ack !== 1'b0 || bus1 !== 10'h255) begin
      bad++;
      $display("[TB] FAIL pl_data_phase ack=%b bus=%h, expected 0/255", pl_ack, bus1);
    end
    tick;
    tick;
    total++;
    if (busy !== 1'b0 || bus1 !== 10'h000) begin
      bad++;
      $display("[TB] FAIL pl_idle busy=%b bus=%h, expected 0/000", busy, bus1);
    end
  endtask

  task automatic test_cpu_vs_player;
    cpu_wren = 1'b1; cpu_a0 = 1'b0; cpu_data = 8'hAA;
    pl_req = 1'b1; pl_reg = 4'h5; pl_data = 8'h66;
    tick;
    cpu_wren = 1'b0;
    total++;
    if (pl_ack !== 1'b0 || bus1 !== 10'h000) begin
      bad++;
      $display("[TB] FAIL arb_no_player_grant ack=%b bus=%h, expected 0/000", pl_ack, bus1);
    end
    tick;
    total++;
    if (pl_ack !== 1'b0 || bus1 !== 10'h307) begin
      bad++;
      $display("[TB] FAIL arb_cpu_first ack=%b bus=%h, expected 0/307", pl_ack, bus1);
    end
    tick;
    total++;
    if (bus1 !== 10'h2AA) begin
      bad++;
      $display("[TB] FAIL arb_cpu_data bus=%h, expected 2aa", bus1);
    end
    tick;
    tick;
    total++;
    if (pl_ack !== 1'b0 || bus1 !== 10'h000) begin
      bad++;
      $display("[TB] FAIL arb_idle_gap ack=%b bus=%h, expected 0/000", pl_ack, bus1);
    end
    tick;
    total++;
    if (pl_ack !== 1'b1 || bus1 !== 10'h305) begin
      bad++;
      $display("[TB] FAIL arb_player_next ack=%b bus=%h, expected 1/305", pl_ack, bus1);
    end
    pl_req = 1'b0;
    tick;
    total++;
    if (pl_ack !== 1'b0 || bus1 !== 10'h266) begin
      bad++;
      $display("[TB] FAIL arb_player_data ack=%b bus=%h, expected 0/266", pl_ack, bus1);
    end
    tick;
    tick;
  endtask

  task automatic test_overflow;
    cpu_wren = 1'b1; cpu_a0 = 1'b0; cpu_data = 8'h11;
    tick;
    cpu_wren = 1'b0;
    tick;
    ce = 1'b0;
    cpu_wren = 1'b1; cpu_data = 8'h22;
    tick;
    total++;
    if (cpu_ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ovf_first_pends ovf=%b, expected 0", cpu_ovf);
    end
    cpu_data = 8'h33;
    tick;
    total++;
    if (cpu_ovf !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovf_second_drop ovf=%b, expected 1", cpu_ovf);
    end
    cpu_data = 8'h44; ovf_clr = 1'b1;
    tick;
    cpu_wren = 1'b0;
    total++;
    if (cpu_ovf !== 1'b1 || bus1 !== 10'h307) begin
      bad++;
      $display("[TB] FAIL ovf_set_wins ovf=%b bus=%h, expected 1/307", cpu_ovf, bus1);
    end
    tick;
    ovf_clr = 1'b0;
    total++;
    if (cpu_ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ovf_clear ovf=%b, expected 0", cpu_ovf);
    end
    ce = 1'b1;
    tick;
    total++;
    if (bus1 !== 10'h211) begin
      bad++;
      $display("[TB] FAIL ovf_first_data bus=%h, expected 211", bus1);
    end
    tick;
    tick;
    total++;
    if (busy !== 1'b1 || bus1 !== 10'h000) begin
      bad++;
      $display("[TB] FAIL ovf_idle_pending busy=%b bus=%h, expected 1/000", busy, bus1);
    end
    cpu_wren = 1'b1; cpu_a0 = 1'b0; cpu_data = 8'h55;
    tick;
    total++;
    if (cpu_ovf !== 1'b0 || busy !== 1'b1 || bus1 !== 10'h307) begin
      bad++;
      $display("[TB] FAIL ovf_grant_edge_write ovf=%b busy=%b bus=%h, expected 0/1/307", cpu_ovf, busy, bus1);
    end
    cpu_a0 = 1'b1; cpu_data = 8'h09;
    tick;
    cpu_wren = 1'b0; cpu_a0 = 1'b0;
    total++;
    if (bus1 !== 10'h222) begin
      bad++;
      $display("[TB] FAIL ovf_pended_data bus=%h, expected 222", bus1);
    end
    tick;
    tick;
    tick;
    total++;
    if (bus1 !== 10'h307) begin
      bad++;
      $display("[TB] FAIL ovf_addr_at_enqueue bus=%h, expected 307", bus1);
    end
    tick;
    total++;
    if (bus1 !== 10'h255) begin
      bad++;
      $display("[TB] FAIL ovf_refill_data bus=%h, expected 255", bus1);
    end
    tick;
    tick;
    total++;
    if (busy !== 1'b0 || cpu_ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ovf_final busy=%b ovf=%b, expected 0/0", busy, cpu_ovf);
    end
  endtask

  task automatic test_slow_ce;
    logic [9:0] exp_bus;
    logic       exp_busy;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    ce2 = 1'b0;
    tick;
    cpu_wren = 1'b1; cpu_a0 = 1'b1; cpu_data = 8'h0A;
    tick;
    cpu_a0 = 1'b0; cpu_data = 8'h77;
    tick;
    cpu_wren = 1'b0;
    tick;
    for (int k = 0; k < 6; k++) tick;
    total++;
    if (bus2 !== 10'h30A || busy2 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL slow_frozen_addr bus=%h busy=%b, expected 30a/1", bus2, busy2);
    end
    for (int i = 1; i <= 24; i++) begin
      ce2 = ((i % 4) == 0);
      tick;
      if (i < 8) exp_bus = 10'h30A;
      else if (i < 16) exp_bus = 10'h277;
      else exp_bus = 10'h000;
      exp_busy = (i < 24);
      total++;
      if (bus2 !== exp_bus || busy2 !== exp_busy) begin
        bad++;
        $display("[TB] FAIL slow_phase_%0d bus=%h busy=%b, expected %h/%b", i, bus2, busy2, exp_bus, exp_busy);
      end
    end
    ce2 = 1'b0;
  endtask

  task automatic test_reset_mid_txn;
    ce = 1'b1;
    cpu_wren = 1'b1; cpu_a0 = 1'b1; cpu_data = 8'h0C;
    tick;
    cpu_a0 = 1'b0; cpu_data = 8'h99;
    tick;
    cpu_wren = 1'b0;
    tick;
    tick;
    ce = 1'b0;
    pl_req = 1'b1; pl_reg = 4'h1; pl_data = 8'h01;
    cpu_wren = 1'b1; cpu_data = 8'hAB;
    tick;
    tick;
    cpu_wren = 1'b0;
    total++;
    if (bus1 !== 10'h299 || cpu_ovf !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_pre_state bus=%h ovf=%b busy=%b, expected 299/1/1", bus1, cpu_ovf, busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus1 !== 10'h000 || busy !== 1'b0 || cpu_ovf !== 1'b0 || pl_ack !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_async bus=%h busy=%b ovf=%b ack=%b, expected 000/0/0/0", bus1, busy, cpu_ovf, pl_ack);
    end
    pl_req = 1'b0;
    tick;
    reset_n = 1'b1;
    ce = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      total++;
      if (bus1 !== 10'h000 || busy !== 1'b0 || pl_ack !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rst_no_stale_%0d bus=%h busy=%b ack=%b, expected 000/0/0", k, bus1, busy, pl_ack);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    ce = 1'b1;
    ce2 = 1'b0;
    cpu_a0 = 1'b0;
    cpu_data = 8'h00;
    cpu_wren = 1'b0;
    pl_req = 1'b0;
    pl_reg = 4'h0;
    pl_data = 8'h00;
    ovf_clr = 1'b0;
    tick;
    test_reset;
    test_cpu_write;
    test_player;
    test_cpu_vs_player;
    test_overflow;
    test_slow_ce;
    test_reset_mid_txn;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
